// File: rtl/dma_req_split.sv
// -----------------------------------------------------------------------------
// dma_req_split
//   Breaks a user DMA request (vaddr, len) into chunks of at most MAX_LEN bytes.
//   No chunk crosses a MAX_LEN-aligned address boundary. A credit counter limits
//   how many chunks can be issued but not yet completed.
//   Use one instance per stream channel and per direction. It feeds the
//   rd/wr request input of the shell clock-crossing stage.
//
// Ports
//   aclk, aresetn        clock; asynchronous active-low reset
//   s_req_*              upstream request (valid/ready, vaddr, len, dest, last)
//   m_req_*              chunk output (valid/ready, vaddr, len, dest, last)
//   s_done_valid         one-cycle pulse that returns one credit
//   outstanding          number of chunks currently in flight
//   err_underflow        sticky; a done pulse arrived with nothing in flight
// -----------------------------------------------------------------------------
module dma_req_split #(
  parameter int ADDR_BITS     = 64,
  parameter int LEN_BITS      = 28,
  parameter int DEST_BITS     = 4,
  parameter int MAX_LEN       = 4096,
  parameter int N_OUTSTANDING = 8
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic                                 s_req_valid,
  output logic                                 s_req_ready,
  input  logic [ADDR_BITS-1:0]                 s_req_vaddr,
  input  logic [LEN_BITS-1:0]                  s_req_len,
  input  logic [DEST_BITS-1:0]                 s_req_dest,
  input  logic                                 s_req_last,
  output logic                                 m_req_valid,
  input  logic                                 m_req_ready,
  output logic [ADDR_BITS-1:0]                 m_req_vaddr,
  output logic [LEN_BITS-1:0]                  m_req_len,
  output logic [DEST_BITS-1:0]                 m_req_dest,
  output logic                                 m_req_last,
  input  logic                                 s_done_valid,
  output logic [$clog2(N_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                 err_underflow
);

  localparam int CNT_W = $clog2(N_OUTSTANDING+1);

  localparam logic [CNT_W-1:0]     MAX_CNT   = CNT_W'(N_OUTSTANDING);
  localparam logic [LEN_BITS-1:0]  MAX_LEN_L = LEN_BITS'(MAX_LEN);
  // Mask that selects the byte offset inside one MAX_LEN window. It is built in
  // full address width so that MAX_LEN == 1 needs no zero-width slice.
  localparam logic [ADDR_BITS-1:0] OFF_MASK  = ADDR_BITS'(MAX_LEN - 1);

  typedef enum logic {IDLE, SPLIT} state_e;

  state_e                 state_q;
  logic                   rdy_q;
  logic [ADDR_BITS-1:0]   vaddr_q;
  logic [LEN_BITS-1:0]    rem_q;
  logic [DEST_BITS-1:0]   dest_q;
  logic                   last_q;
  logic [CNT_W-1:0]       out_q;
  logic                   err_q;

  logic [LEN_BITS-1:0]    offset;
  logic [LEN_BITS-1:0]    space;
  logic [LEN_BITS-1:0]    chunk;
  logic                   final_chunk;
  logic                   credit_ok;
  logic                   hs;
  logic                   accept;

  // ---------------------------------------------------------------------------
  // Chunk sizing. This uses registers only, so the m_req_* fields cannot change
  // while a chunk is waiting for ready. The offset is always below MAX_LEN, and
  // MAX_LEN <= 2^(LEN_BITS-1), so truncating it to LEN_BITS loses nothing.
  // ---------------------------------------------------------------------------
  always_comb begin
    offset      = LEN_BITS'(vaddr_q & OFF_MASK);
    space       = MAX_LEN_L - offset;
    chunk       = (rem_q < space) ? rem_q : space;
    final_chunk = (chunk == rem_q);
  end

  // Credits can only grow while a chunk waits, so valid never drops before
  // the handshake.
  assign credit_ok   = (out_q < MAX_CNT);
  assign m_req_valid = (state_q == SPLIT) && credit_ok;
  assign hs          = m_req_valid && m_req_ready;
  assign accept      = s_req_valid && rdy_q;

  assign s_req_ready   = rdy_q;
  assign m_req_vaddr   = vaddr_q;
  assign m_req_len     = chunk;
  assign m_req_dest    = dest_q;
  // last_q and rem_q keep stale values after a request ends. Gating with the
  // state keeps last low while the block is idle.
  assign m_req_last    = (state_q == SPLIT) && last_q && final_chunk;
  assign outstanding   = out_q;
  assign err_underflow = err_q;

  // ---------------------------------------------------------------------------
  // Request FSM. Ready is held low for the cycle after each acceptance. A
  // zero-length request therefore comes back to ready=1 one cycle later,
  // without leaving IDLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      vaddr_q <= '0;
      rem_q   <= '0;
      dest_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            vaddr_q <= s_req_vaddr;
            rem_q   <= s_req_len;
            dest_q  <= s_req_dest;
            last_q  <= s_req_last;
            rdy_q   <= 1'b0;
            if (s_req_len != '0) state_q <= SPLIT;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        SPLIT: begin
          if (hs) begin
            // The address wraps modulo 2^ADDR_BITS.
            vaddr_q <= vaddr_q + ADDR_BITS'(chunk);
            rem_q   <= rem_q - chunk;
            if (final_chunk) begin
              state_q <= IDLE;
              rdy_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Credit counter. An issue and a completion in the same cycle cancel out. A
  // completion with nothing in flight leaves the count at 0 and latches the
  // error. The count cannot go above N_OUTSTANDING because m_req_valid is held
  // low at the limit.
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      case ({hs, s_done_valid})
        2'b10: out_q <= out_q + CNT_W'(1);
        2'b01: begin
          if (out_q == '0) err_q <= 1'b1;
          else             out_q <= out_q - CNT_W'(1);
        end
        default: out_q <= out_q;
      endcase
    end
  end

endmodule
